// File: rtl/axis_join.sv
`default_nettype none
// ============================================================================
//  Module   : axis_join
//  Brief    : Joins N AXI-Stream channels into one wide beat. Each channel is
//             buffered by its own first-word-fall-through FIFO; the output
//             fires only when every FIFO holds a beat and pops them all at
//             once. Flags last-flag disagreement and counts joined packets.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_join #(
  parameter int N     = 2,
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int CW    = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [N-1:0]   s_valid,
  output logic [N-1:0]   s_ready,
  input  logic [N*W-1:0] s_data,
  input  logic [N-1:0]   s_last,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [N*W-1:0] m_data,
  output logic           m_last,
  output logic           err_last,
  input  logic           clr_err,
  output logic [CW-1:0]  pkt_count
);

  localparam int              c_AW   = $clog2(DEPTH);
  localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(DEPTH);

  logic [N-1:0]        w_not_empty;
  logic [N-1:0]        w_full;
  logic [N-1:0]        w_head_last;
  logic [N-1:0][W-1:0] w_head_data;
  logic                w_xfer;
  logic                w_last_all;
  logic                w_last_mismatch;

  // One transfer pops every FIFO together
  assign w_xfer          = m_valid & m_ready;
  assign w_last_all      = &w_head_last;
  assign w_last_mismatch = (|w_head_last) & ~w_last_all;

  assign m_valid = &w_not_empty;
  assign m_last  = m_valid & w_last_all;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [W:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_AW:0]   r_count;
    logic            w_wr;

    assign w_wr           = s_valid[i] & s_ready[i];
    assign w_full[i]      = (r_count == c_FULL);
    assign w_not_empty[i] = (r_count != '0);
    // Ready comes from registered occupancy only; gating with rstn keeps it
    // low while reset is held and high right after it is released.
    assign s_ready[i]     = ~w_full[i] & rstn;

    assign w_head_data[i] = r_mem[r_rd_ptr][W-1:0];
    assign w_head_last[i] = r_mem[r_rd_ptr][W];
    // Output data is forced to zero whenever no joined beat is presented
    assign m_data[i*W +: W] = m_valid ? w_head_data[i] : '0;

    // Storage array; contents are only meaningful where occupancy says so
    always_ff @(posedge clk) begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= {s_last[i], s_data[i*W +: W]};
      end
    end

    // Pointers wrap naturally modulo DEPTH; occupancy tracks write minus pop
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_wr) begin
          r_wr_ptr <= r_wr_ptr + c_AW'(1);
        end
        if (w_xfer) begin
          r_rd_ptr <= r_rd_ptr + c_AW'(1);
        end
        if (w_wr && !w_xfer) begin
          r_count <= r_count + (c_AW+1)'(1);
        end else if (!w_wr && w_xfer) begin
          r_count <= r_count - (c_AW+1)'(1);
        end
      end
    end
  end

  // Sticky last-mismatch flag; a new mismatch beats a simultaneous clear
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_last <= 1'b0;
    end else if (w_xfer && w_last_mismatch) begin
      err_last <= 1'b1;
    end else if (clr_err) begin
      err_last <= 1'b0;
    end
  end

  // Count every joined beat that closes a packet, wrapping at 2^CW
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_count <= '0;
    end else if (w_xfer && w_last_all) begin
      pkt_count <= pkt_count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_join.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_join
//  Brief    : Scoreboard bench for axis_join. Per-channel queues model the
//             FIFO contents; a negedge monitor compares every output against
//             the queue heads and the expected flag/counter state.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_join;

  localparam int N     = 2;
  localparam int W     = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 16;

  logic           clk = 1'b0;
  logic           rstn;
  logic [N-1:0]   s_valid;
  logic [N-1:0]   s_ready;
  logic [N*W-1:0] s_data;
  logic [N-1:0]   s_last;
  logic           m_valid;
  logic           m_ready;
  logic [N*W-1:0] m_data;
  logic           m_last;
  logic           err_last;
  logic           clr_err;
  logic [CW-1:0]  pkt_count;

  logic           v [N];
  logic [W-1:0]   d [N];
  logic           l [N];
  bit             rand_ready;

  assign s_valid = {v[1], v[0]};
  assign s_data  = {d[1], d[0]};
  assign s_last  = {l[1], l[0]};

  always #5 clk = ~clk;

  axis_join #(.N(N), .W(W), .DEPTH(DEPTH), .CW(CW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_last   (m_last),
    .err_last (err_last),
    .clr_err  (clr_err),
    .pkt_count(pkt_count)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // Stimulus beats waiting to be offered, and the reference FIFO contents
  logic [W:0] stim [N][$];
  logic [W:0] mq   [N][$];
  int         exp_pkt = 0;
  bit         exp_err = 1'b0;

  // Reference model: a joined beat exists when every channel queue holds one
  always @(negedge clk) begin : monitor
    bit             mv, ml, any_last, mis;
    int             room [N];
    logic [N*W-1:0] md;
    if (!rstn) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      exp_pkt = 0;
      exp_err = 1'b0;
      chk("rst_s_ready",   32'(s_ready),   32'd0);
      chk("rst_m_valid",   32'(m_valid),   32'd0);
      chk("rst_m_data",    32'(m_data),    32'd0);
      chk("rst_m_last",    32'(m_last),    32'd0);
      chk("rst_err_last",  32'(err_last),  32'd0);
      chk("rst_pkt_count", 32'(pkt_count), 32'd0);
    end else begin
      mv = 1'b1;
      for (int i = 0; i < N; i++) begin
        room[i] = DEPTH - mq[i].size();
        if (mq[i].size() == 0) mv = 1'b0;
        chk($sformatf("s_ready%0d", i), 32'(s_ready[i]), 32'(room[i] > 0));
      end
      chk("m_valid",   32'(m_valid),   32'(mv));
      chk("pkt_count", 32'(pkt_count), 32'(exp_pkt));
      chk("err_last",  32'(err_last),  32'(exp_err));
      mis = 1'b0;
      if (mv) begin
        ml       = 1'b1;
        any_last = 1'b0;
        md       = '0;
        for (int i = 0; i < N; i++) begin
          md[i*W +: W] = mq[i][0][W-1:0];
          ml           = ml & mq[i][0][W];
          any_last     = any_last | mq[i][0][W];
        end
        chk("m_data", 32'(m_data), 32'(md));
        chk("m_last", 32'(m_last), 32'(ml));
        if (m_ready) begin
          for (int i = 0; i < N; i++) void'(mq[i].pop_front());
          if (ml) exp_pkt = (exp_pkt + 1) % (1 << CW);
          mis = any_last & ~ml;
        end
      end
      if (mis) exp_err = 1'b1;
      else if (clr_err) exp_err = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (s_valid[i] && room[i] > 0) mq[i].push_back({s_last[i], s_data[i*W +: W]});
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic add_beat(input int ch, input logic [W-1:0] dd, input logic ll);
    stim[ch].push_back({ll, dd});
  endtask

  // Offer queued beats on one channel, holding each until accepted
  task automatic drive_ch(input int ch, input bit rnd);
    int wait_c;
    bit acc;
    wait_c = 0;
    while (stim[ch].size() > 0) begin
      if (rnd && $urandom_range(1, 0) == 0) begin
        v[ch] = 1'b0;
        cyc();
      end else begin
        v[ch] = 1'b1;
        d[ch] = stim[ch][0][W-1:0];
        l[ch] = stim[ch][0][W];
        @(negedge clk);
        acc = s_ready[ch];
        @(posedge clk);
        #1;
        if (acc) begin
          void'(stim[ch].pop_front());
          wait_c = 0;
        end else begin
          wait_c++;
          if (wait_c > 500) begin
            fail_now($sformatf("drive_timeout_ch%0d", ch));
            stim[ch].delete();
          end
        end
      end
    end
    v[ch] = 1'b0;
  endtask

  initial begin : ready_gen
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) m_ready = 1'($urandom_range(1, 0));
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int cnt;
    int len;
    rstn = 1'b0;
    m_ready = 1'b0;
    clr_err = 1'b0;
    rand_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; d[i] = '0; l[i] = 1'b0;
    end
    cyc(3);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_reset_s_ready", 32'(s_ready), 32'h3);
    @(posedge clk); #1;

    // Two-beat packet on both channels at full rate
    m_ready = 1'b1;
    add_beat(0, 8'h11, 1'b0); add_beat(0, 8'h22, 1'b1);
    add_beat(1, 8'hA1, 1'b0); add_beat(1, 8'hA2, 1'b1);
    fork drive_ch(0, 1'b0); drive_ch(1, 1'b0); join
    cyc(4);
    chk("basic_pkt_count", 32'(pkt_count), 32'd1);
    chk("basic_err_last",  32'(err_last),  32'd0);

    // Channel 1 idle while channel 0 fills up
    for (int k = 0; k < 5; k++) add_beat(0, 8'(8'h30 + k), k == 4);
    fork
      drive_ch(0, 1'b0);
      begin
        cyc(7);
        @(negedge clk);
        chk("fill_s_ready0", 32'(s_ready[0]), 32'd0);
        chk("fill_m_valid",  32'(m_valid),    32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) add_beat(1, 8'(8'hB0 + k), k == 4);
        drive_ch(1, 1'b0);
      end
    join
    cyc(4);
    chk("fill_pkt_count", 32'(pkt_count), 32'd2);

    // Back-pressure with both FIFOs full
    m_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      add_beat(0, 8'(8'h40 + k), k == 5);
      add_beat(1, 8'(8'hC0 + k), k == 5);
    end
    fork drive_ch(0, 1'b0); drive_ch(1, 1'b0); join_none
    cyc(6);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("stall_s_ready", 32'(s_ready), 32'd0);
      chk("stall_m_data",  32'(m_data),  32'hC040);
      @(posedge clk); #1;
    end
    m_ready = 1'b1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (m_valid) cnt++;
      @(posedge clk); #1;
    end
    chk("release_xfers", 32'(cnt), 32'd4);
    wait fork;
    cyc(5);
    chk("stall_pkt_count", 32'(pkt_count), 32'd3);

    // Last-flag disagreement, then clear
    add_beat(0, 8'h55, 1'b1);
    add_beat(1, 8'h66, 1'b0);
    fork drive_ch(0, 1'b0); drive_ch(1, 1'b0); join
    cyc(3);
    chk("mis_err_set",   32'(err_last),  32'd1);
    chk("mis_pkt_count", 32'(pkt_count), 32'd3);
    cyc(5);
    chk("mis_err_hold",  32'(err_last),  32'd1);
    clr_err = 1'b1;
    cyc();
    clr_err = 1'b0;
    @(negedge clk);
    chk("mis_err_clear", 32'(err_last), 32'd0);
    @(posedge clk); #1;

    // Mismatch while clear is held: set must win on the transfer cycle
    clr_err = 1'b1;
    add_beat(0, 8'h77, 1'b0);
    add_beat(1, 8'h88, 1'b1);
    fork drive_ch(0, 1'b0); drive_ch(1, 1'b0); join
    cyc(3);
    clr_err = 1'b0;
    cyc(2);

    // Reset in the middle of a packet
    m_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      add_beat(0, 8'(8'h90 + k), 1'b0);
      add_beat(1, 8'(8'hD0 + k), 1'b0);
    end
    fork drive_ch(0, 1'b0); drive_ch(1, 1'b0); join
    cyc();
    rstn = 1'b0;
    cyc(3);
    @(negedge clk);
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    rstn = 1'b1;
    m_ready = 1'b1;
    add_beat(0, 8'hE1, 1'b1);
    add_beat(1, 8'hF1, 1'b1);
    fork drive_ch(0, 1'b0); drive_ch(1, 1'b0); join
    cyc(4);
    chk("midrst_pkt_count", 32'(pkt_count), 32'd1);

    // Random traffic: 200 packets, matching lengths on both channels
    rstn = 1'b0;
    cyc(2);
    rstn = 1'b1;
    cyc();
    for (int p = 0; p < 200; p++) begin
      len = $urandom_range(30, 1);
      for (int k = 0; k < len; k++) begin
        add_beat(0, 8'($urandom), k == len - 1);
        add_beat(1, 8'($urandom), k == len - 1);
      end
    end
    rand_ready = 1'b1;
    fork drive_ch(0, 1'b1); drive_ch(1, 1'b1); join
    rand_ready = 1'b0;
    m_ready = 1'b1;
    cnt = 0;
    while ((mq[0].size() > 0 || mq[1].size() > 0) && cnt < 100) begin
      cyc();
      cnt++;
    end
    if (cnt >= 100) fail_now("drain_timeout");
    cyc(3);
    chk("rand_pkt_count", 32'(pkt_count), 32'd200);
    chk("rand_err_last",  32'(err_last),  32'd0);
    chk("rand_m_valid",   32'(m_valid),   32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
